// File: rtl/fifo_wr_arbiter_pkg.sv
// rtl/fifo_wr_arbiter_pkg.sv - shared state type and default sizing for the FIFO write-port arbiter
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  localparam int DEF_DATA_W    = 32;
  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_MAX_BURST = 8;

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// rtl/fifo_wr_arbiter_rr_picker.sv - round-robin search for the first set request at or after ptr_i
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int N  = DEF_NUM_REQ,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o
);

  logic [IW-1:0] cand;

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    // Offsets walked high to low so the request nearest ptr_i is written last and wins.
    for (int k = N - 1; k >= 0; k--) begin
      cand = IW'((int'(ptr_i) + k) % N);
      if (req_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin arbiter sharing the FIFO write port among NUM_REQ producers
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = DEF_MAX_BURST,
  localparam int IDW      = $clog2(NUM_REQ)
) (
  input  logic                      rst_n,
  input  logic                      wr_clk,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic                      fifo_full_n_i,
  output logic                      fifo_wr_en_o,
  output logic [DATA_W-1:0]         fifo_data_o,
  output logic [IDW-1:0]            grant_id_o,
  output logic                      busy_o,
  output logic [15:0]               beats_total_o
);

  localparam int              CNTW      = $clog2(MAX_BURST + 1);
  localparam logic [CNTW-1:0] LAST_BEAT = CNTW'(MAX_BURST);
  localparam logic [IDW-1:0]  LAST_ID   = IDW'(NUM_REQ - 1);

  arb_state_t      state_q;
  logic [IDW-1:0]  grant_q;
  logic [IDW-1:0]  rr_ptr_q;
  logic [CNTW-1:0] burst_cnt_q;
  logic [CNTW-1:0] burst_cnt_d;
  logic [15:0]     beats_total_q;
  logic            busy_q;
  logic            pick_found;
  logic [IDW-1:0]  pick_idx;
  logic            in_burst;
  logic            gnt_valid;
  logic            beat;
  logic            burst_done;
  logic [IDW-1:0]  next_ptr;

  rr_picker #(
    .N  (NUM_REQ),
    .IW (IDW)
  ) u_rr_picker (
    .req_i   (req_valid_i),
    .ptr_i   (rr_ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  assign in_burst    = (state_q == BURST);
  assign gnt_valid   = req_valid_i[grant_q];
  assign beat        = in_burst & gnt_valid & fifo_full_n_i;
  assign burst_cnt_d = burst_cnt_q + 1'b1;
  assign burst_done  = beat & (burst_cnt_d == LAST_BEAT);
  assign next_ptr    = (grant_q == LAST_ID) ? '0 : grant_q + 1'b1;

  // Handshake decodes straight from state so an async reset drops it without waiting for a clock.
  always_comb begin
    req_ready_o = '0;
    if (in_burst) req_ready_o[grant_q] = fifo_full_n_i;
  end

  assign fifo_wr_en_o  = beat;
  assign fifo_data_o   = in_burst ? req_data_i[grant_q*DATA_W +: DATA_W] : '0;
  assign grant_id_o    = in_burst ? grant_q : '0;
  assign busy_o        = busy_q;
  assign beats_total_o = beats_total_q;

  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            grant_q     <= pick_idx;
            burst_cnt_q <= '0;
            state_q     <= BURST;
            busy_q      <= 1'b1;
          end
        end
        BURST: begin
          if (beat) burst_cnt_q <= burst_cnt_d;
          if (!gnt_valid || burst_done) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            rr_ptr_q <= next_ptr;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) beats_total_q <= '0;
    else if (beat) beats_total_q <= beats_total_q + 16'd1;
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed and randomized checks of fifo_wr_arbiter against a rule-level model
module tb_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int DW = 32;

  logic            wr_clk = 1'b0;
  logic            rst_n;
  logic [NR-1:0]   req_valid, req_ready, req_valid2, req_ready2;
  logic [NR*DW-1:0] req_data, req_data2;
  logic            full_n, full_n2, wr_en, wr_en2, busy, busy2;
  logic [DW-1:0]   fdata, fdata2;
  logic [1:0]      gid, gid2;
  logic [15:0]     total, total2;

  always #5 wr_clk = ~wr_clk;

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .MAX_BURST(8)) u_dut (
    .rst_n(rst_n), .wr_clk(wr_clk), .req_valid_i(req_valid), .req_data_i(req_data),
    .req_ready_o(req_ready), .fifo_full_n_i(full_n), .fifo_wr_en_o(wr_en), .fifo_data_o(fdata),
    .grant_id_o(gid), .busy_o(busy), .beats_total_o(total)
  );

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .MAX_BURST(2)) u_dut2 (
    .rst_n(rst_n), .wr_clk(wr_clk), .req_valid_i(req_valid2), .req_data_i(req_data2),
    .req_ready_o(req_ready2), .fifo_full_n_i(full_n2), .fifo_wr_en_o(wr_en2), .fifo_data_o(fdata2),
    .grant_id_o(gid2), .busy_o(busy2), .beats_total_o(total2)
  );

  typedef struct {
    bit busy;
    int gid;
    int ptr;
    int cnt;
    int total;
  } ms_t;

  ms_t         m1, m2;
  int          remain[NR];
  int          sent[NR];
  logic [31:0] base[NR];
  int          nchk = 0;
  int          nfail = 0;
  logic [31:0] cap[$];
  bit          we_hist[$];
  int          g2_log[$];
  int          runs[$];
  int          gaps[$];
  int          r, z;

  function automatic void chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endfunction

  // Behavioural arbiter: whoever is nearest the pointer wins, a grant lasts until maxb beats or valid drops.
  function automatic void mstep(input ms_t s, input logic [NR-1:0] v, input logic fn, input int maxb,
                                output ms_t n, output logic we, output logic [NR-1:0] rdy);
    bit got;
    int cand;
    n   = s;
    we  = 1'b0;
    rdy = '0;
    got = 1'b0;
    if (!s.busy) begin
      for (int off = 0; off < NR; off++) begin
        cand = (s.ptr + off) % NR;
        if (!got && v[cand]) begin
          got    = 1'b1;
          n.busy = 1'b1;
          n.gid  = cand;
          n.cnt  = 0;
        end
      end
    end else begin
      rdy[s.gid] = fn;
      if (!v[s.gid]) begin
        n.busy = 1'b0;
        n.ptr  = (s.gid + 1) % NR;
      end else if (fn) begin
        we      = 1'b1;
        n.cnt   = s.cnt + 1;
        n.total = (s.total + 1) % 65536;
        if (n.cnt == maxb) begin
          n.busy = 1'b0;
          n.ptr  = (s.gid + 1) % NR;
        end
      end
    end
  endfunction

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      req_valid[i]          = (remain[i] > 0);
      req_data[i*DW +: DW]  = base[i] + sent[i];
    end
  endtask

  task automatic tick();
    ms_t n;
    logic we, we2;
    logic [NR-1:0] rdy, rdy2;
    drive();
    #1;
    mstep(m1, req_valid, full_n, 8, n, we, rdy);
    chk("wr_en", wr_en, we);
    chk("req_ready", req_ready, rdy);
    chk("busy", busy, m1.busy);
    chk("beats_total", total, m1.total);
    if (m1.busy) chk("grant_id", gid, m1.gid);
    if (we) chk("fifo_data", fdata, base[m1.gid] + sent[m1.gid]);
    we_hist.push_back(wr_en);
    if (wr_en) cap.push_back(fdata);
    if (we) begin
      sent[m1.gid]++;
      remain[m1.gid]--;
    end
    m1 = n;
    mstep(m2, req_valid2, full_n2, 2, n, we2, rdy2);
    chk("d2_wr_en", wr_en2, we2);
    chk("d2_req_ready", req_ready2, rdy2);
    chk("d2_busy", busy2, m2.busy);
    if (m2.busy) chk("d2_grant_id", gid2, m2.gid);
    if (we2) chk("d2_fifo_data", fdata2, req_data2[m2.gid*DW +: DW]);
    if (wr_en2) g2_log.push_back(int'(gid2));
    m2 = n;
    @(posedge wr_clk);
    #2;
  endtask

  task automatic drain(input int limit);
    for (int c = 0; c < limit && (m1.busy || remain[0] + remain[1] + remain[2] + remain[3] > 0); c++) tick();
    chk("drain_done", remain[0] + remain[1] + remain[2] + remain[3], 0);
  endtask

  initial begin
    rst_n      = 1'b0;
    full_n     = 1'b1;
    full_n2    = 1'b1;
    req_valid  = '0;
    req_data   = '0;
    req_valid2 = '0;
    for (int i = 0; i < NR; i++) begin
      remain[i] = 0;
      sent[i]   = 0;
      base[i]   = 32'h0;
      req_data2[i*DW +: DW] = 32'hA0 + i;
    end
    m1 = '{default: 0};
    m2 = '{default: 0};
    @(posedge wr_clk);
    #3;
    chk("rst_busy", busy, 1'b0);
    chk("rst_wr_en", wr_en, 1'b0);
    chk("rst_ready", req_ready, 4'h0);
    chk("rst_total", total, 16'h0);
    chk("rst_grant", gid, 2'd0);
    @(posedge wr_clk);
    #2;
    rst_n = 1'b1;

    // Single producer, 20 words: bursts 8/8/4 with one bubble between.
    base[0] = 32'h100; remain[0] = 20; sent[0] = 0;
    cap.delete(); we_hist.delete();
    drain(100);
    chk("t1_count", cap.size(), 20);
    foreach (cap[k]) chk("t1_word", cap[k], 32'h100 + k);
    runs.delete(); gaps.delete(); r = 0; z = 0;
    foreach (we_hist[k]) begin
      if (we_hist[k]) begin
        if (r == 0 && runs.size() > 0) gaps.push_back(z);
        r++; z = 0;
      end else begin
        if (r > 0) begin runs.push_back(r); r = 0; end
        z++;
      end
    end
    if (r > 0) runs.push_back(r);
    chk("t1_nbursts", runs.size(), 3);
    if (runs.size() == 3) begin
      chk("t1_burst0", runs[0], 8);
      chk("t1_burst1", runs[1], 8);
      chk("t1_burst2", runs[2], 4);
    end
    chk("t1_ngaps", gaps.size(), 2);
    foreach (gaps[k]) chk("t1_gap", gaps[k], 1);
    chk("t1_total", total, 16'd20);

    // MAX_BURST=2 instance, all producers requesting: 0,1,2,3,0,... two beats each.
    g2_log.delete();
    req_valid2 = 4'hF;
    repeat (30) tick();
    chk("t2_enough_beats", g2_log.size() >= 16, 1'b1);
    for (int k = 0; k < 16 && k < g2_log.size(); k++) chk("t2_order", g2_log[k], (k / 2) % 4);
    req_valid2 = 4'h0;
    repeat (3) tick();

    // Producer 2 stalled by full_n for 5 cycles mid-burst.
    base[2] = 32'h200; remain[2] = 8; sent[2] = 0;
    cap.delete();
    for (int c = 0; c < 20 && sent[2] < 3; c++) tick();
    chk("t3_grant", gid, 2'd2);
    full_n = 1'b0;
    repeat (5) begin
      drive();
      #1;
      chk("t3_stall_we", wr_en, 1'b0);
      chk("t3_stall_ready", req_ready, 4'h0);
      chk("t3_stall_grant", gid, 2'd2);
      tick();
    end
    full_n = 1'b1;
    drain(50);
    chk("t3_count", cap.size(), 8);
    foreach (cap[k]) chk("t3_word", cap[k], 32'h200 + k);

    // Producer 1 drops valid after 3 beats; pointer moves to 2, so 3 beats 0.
    base[1] = 32'h300; remain[1] = 3; sent[1] = 0;
    for (int c = 0; c < 5 && !m1.busy; c++) tick();
    chk("t4_grant1", gid, 2'd1);
    base[0] = 32'h400; remain[0] = 4; sent[0] = 0;
    base[3] = 32'h500; remain[3] = 4; sent[3] = 0;
    for (int c = 0; c < 20 && remain[1] > 0; c++) tick();
    chk("t4_beats1", sent[1], 3);
    tick();
    for (int c = 0; c < 10 && !busy; c++) tick();
    chk("t4_next_grant", gid, 2'd3);
    drain(100);

    // Reset during the 4th beat of a burst.
    base[2] = 32'h600; remain[2] = 10; sent[2] = 0;
    for (int c = 0; c < 20 && sent[2] < 3; c++) tick();
    drive();
    #1;
    chk("t5_pre_we", wr_en, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_we", wr_en, 1'b0);
    chk("t5_rst_ready", req_ready, 4'h0);
    chk("t5_rst_busy", busy, 1'b0);
    chk("t5_rst_total", total, 16'h0);
    m1 = '{default: 0};
    m2 = '{default: 0};
    remain[2] = 0;
    base[1] = 32'h700; remain[1] = 2; sent[1] = 0;
    base[3] = 32'h800; remain[3] = 2; sent[3] = 0;
    @(posedge wr_clk);
    #2;
    rst_n = 1'b1;
    chk("t5_total_after", total, 16'h0);
    for (int c = 0; c < 5 && !busy; c++) tick();
    chk("t5_first_grant", gid, 2'd1);
    drain(50);

    // Randomized traffic with random back-pressure.
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 2) == 0) begin
        int p;
        p = $urandom_range(0, NR - 1);
        if (remain[p] == 0) begin
          remain[p] = $urandom_range(1, 12);
          base[p]   = $urandom;
          sent[p]   = 0;
        end
      end
      full_n = ($urandom_range(0, 3) != 0);
      tick();
    end
    full_n = 1'b1;
    drain(300);

    // beats_total wraps to 0 after 65536 beats.
    rst_n = 1'b0;
    m1 = '{default: 0};
    m2 = '{default: 0};
    @(posedge wr_clk);
    #2;
    rst_n = 1'b1;
    base[0] = 32'h0; remain[0] = 65536; sent[0] = 0;
    for (int c = 0; c < 80000 && (remain[0] > 0 || m1.busy); c++) begin
      tick();
      if (we_hist.size() > 64) begin
        we_hist.delete();
        cap.delete();
      end
    end
    chk("t6_done", remain[0], 0);
    chk("t6_wrap", total, 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
